// File: rtl/buart_tx_fifo.sv
// Buffered 8N1 UART transmitter: 8-entry byte FIFO feeding a shifter, idle-high warm-up after reset.
// Write-to-start-bit latency 2 cycles from an idle line; writes are dropped while busy (FIFO full).
module buart_tx_fifo #(
  parameter int CFG_DIVIDER = 104,
  parameter int WARMUP_BITS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       busy,
  output logic       idle,
  output logic [3:0] level
);
  localparam int CW = $clog2(CFG_DIVIDER);
  localparam int WW = (WARMUP_BITS > 1) ? $clog2(WARMUP_BITS) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CFG_DIVIDER - 1);
  localparam logic [WW-1:0] WARM_MAX = WW'(WARMUP_BITS - 1);

  typedef enum logic [2:0] {WARMUP, IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [7:0]      mem [8];
  logic [2:0]      wptr;
  logic [2:0]      rptr;
  logic [CW-1:0]   cnt;
  logic [WW-1:0]   warm_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            bit_end;
  logic            push;
  logic            pop;

  assign bit_end = (cnt == CNT_MAX);
  assign push    = wr && (level != 4'd8);
  // The shifter pulls from the FIFO either straight from IDLE or on the final stop cycle.
  assign pop     = (level != 4'd0) &&
                   ((state == IDLE) || ((state == STOP) && bit_end));

  assign busy = (level == 4'd8);
  assign idle = (state == IDLE) && (level == 4'd0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= 3'd0;
      rptr  <= 3'd0;
      level <= 4'd0;
    end else begin
      if (push) wptr <= wptr + 3'd1;
      if (pop)  rptr <= rptr + 3'd1;
      case ({push, pop})
        2'b10:   level <= level + 4'd1;
        2'b01:   level <= level - 4'd1;
        default: level <= level;
      endcase
    end
  end

  // tx follows the state one cycle late, so a pop at edge N+1 shows a start bit from N+2.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= WARMUP;
      cnt      <= '0;
      warm_cnt <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'hFF;
      tx       <= 1'b1;
    end else begin
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift[0];
        default: tx <= 1'b1;
      endcase

      cnt <= bit_end ? '0 : cnt + CW'(1);

      case (state)
        WARMUP: begin
          if (bit_end) begin
            if (warm_cnt == WARM_MAX) state <= IDLE;
            else                      warm_cnt <= warm_cnt + WW'(1);
          end
        end
        IDLE: begin
          cnt <= '0;
          if (pop) begin
            shift <= mem[rptr];
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_idx <= 3'd0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift   <= {1'b1, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              shift <= mem[rptr];
              state <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= WARMUP;
      endcase
    end
  end
endmodule

// File: doc/buart_tx_fifo.md
BUART_TX_FIFO -- requirements
Module: buart_tx_fifo

Interface
REQ-001 Parameter CFG_DIVIDER, default 104, clock cycles per UART bit time; legal range 2..65535.
REQ-002 Parameter WARMUP_BITS, default 15, idle-high bit times driven on tx after reset before the first frame.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous reset, active-high.
REQ-005 wr  input  1  push strobe; tx_data is written to the FIFO when wr=1 and busy=0.
REQ-006 tx_data  input  8  byte to enqueue.
REQ-007 tx  output  1  serial line, 8N1, LSB first, idle high, registered.
REQ-008 busy  output  1  FIFO full (level==8); writes are ignored while high.
REQ-009 idle  output  1  high when FIFO empty, shifter in IDLE and warm-up complete.
REQ-010 level  output  4  FIFO occupancy, 0..8.

Function
REQ-011 The block SHALL contain an 8-entry x 8-bit FIFO: 3-bit write and read pointers wrapping 7->0, plus a 4-bit occupancy counter; all 8 entries are usable.
REQ-012 A write SHALL be accepted iff wr=1 and level<8 at the sampling edge; the write pointer advances by 1 and level increments, unless a pop occurs in the same cycle.
REQ-013 A write with level==8 SHALL be dropped with no pointer or level change, even if a pop occurs in the same cycle.
REQ-014 A simultaneous accepted write and pop SHALL leave level unchanged and advance both pointers.
REQ-015 The transmit FSM SHALL have states WARMUP, IDLE, START, DATA, STOP.
REQ-016 WARMUP: tx=1 for WARMUP_BITS*CFG_DIVIDER cycles, then IDLE; writes are accepted during WARMUP.
REQ-017 IDLE: if level>0, pop the head entry into the 8-bit shift register and go to START; otherwise remain, tx=1.
REQ-018 START: tx=0 for CFG_DIVIDER cycles, then DATA.
REQ-019 DATA: tx=shift[0] for CFG_DIVIDER cycles per bit, shift right after each bit, 8 bits via a 3-bit bit counter, then STOP.
REQ-020 STOP: tx=1 for CFG_DIVIDER cycles; on the last stop cycle, if level>0, pop and go directly to START (zero-gap back-to-back frames); otherwise go to IDLE.
REQ-021 The bit-time counter SHALL be $clog2(CFG_DIVIDER) bits wide minimum, restart at 0 on every state/bit transition and count 0..CFG_DIVIDER-1; every bit lasts exactly CFG_DIVIDER cycles.
REQ-022 Latency: a write sampled at edge N into an empty FIFO with FSM in IDLE SHALL pop at edge N+1 and drive tx=0 from edge N+2.
REQ-023 A frame SHALL be exactly 10*CFG_DIVIDER cycles from the first start-bit cycle to the last stop-bit cycle.
REQ-024 tx_data SHALL be sampled only at the accepting edge; later changes do not affect queued bytes.
REQ-025 level, busy and idle SHALL be registered or derived only from registered state (no combinational path from wr).

Reset
REQ-026 While reset=1 at an edge: tx=1, busy=0, idle=0, level=0, pointers=0, bit counter=0, FSM=WARMUP, shift register=0xFF; FIFO contents are don't-care.
REQ-027 Reset asserted mid-frame SHALL abort the frame, with tx=1 from the next edge; queued bytes are discarded and WARMUP restarts after release.
REQ-028 wr asserted in the same cycle as reset SHALL be ignored.

Verification (CFG_DIVIDER=4, WARMUP_BITS=15)
REQ-029 Release reset -> tx=1 for 60 cycles, idle=0 during WARMUP, idle=1 from cycle 60.
REQ-030 After warm-up, single wr of 0x55 at edge N -> idle drops, tx=0 from N+2, then 1,0,1,0,1,0,1,0 (LSB first) then stop=1, each held 4 cycles, idle=1 after 40 cycles.
REQ-031 During WARMUP write 0x01..0x09 on consecutive cycles -> busy=1 and level=8 after the 8th write, 0x09 dropped, then 8 contiguous frames 0x01..0x08 totalling 320 cycles with no idle gap.
REQ-032 With level=3 mid-transmission, wr coincident with the STOP-to-START pop -> level remains 3, the new byte is sent last, order preserved across pointer wrap.
REQ-033 Reset pulsed during data bit 4 of 0xA5 with 2 bytes queued -> tx=1 next edge, level=0, 60-cycle warm-up, no frame emitted afterwards.
